// File: rtl/ascii_to_ps2_tx.sv
// ascii_to_ps2_tx
//   Keyboard-side PS/2 emulator. It accepts one ASCII character per
//   valid/ready handshake and maps it to a set-2 make code plus a shift flag.
//   It then sends the make/break byte sequence as device-to-host PS/2 frames.
// Ports:
//   clk          system clock, rising edge
//   resetn       synchronous active-low reset
//   ascii_in     character to send
//   ascii_valid  ascii_in valid
//   ascii_ready  high only while idle; transfer on valid & ready at clk edge
//   ps2_clk_o    generated PS/2 clock, idles high
//   ps2_dat_o    PS/2 data, idles high
//   busy         high from the cycle after acceptance until idle again
//   unmapped     one-cycle pulse when the accepted character has no mapping
module ascii_to_ps2_tx #(
   parameter int unsigned HALF_PERIOD = 2500,
   parameter int unsigned BYTE_GAP    = 5000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] ascii_in,
   input  logic       ascii_valid,
   output logic       ascii_ready,
   output logic       ps2_clk_o,
   output logic       ps2_dat_o,
   output logic       busy,
   output logic       unmapped
);

   localparam int unsigned HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int unsigned GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(BYTE_GAP - 1);

   typedef enum logic [1:0] {IDLE, LOAD, FRAME, GAP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    code_q, code_d;
   logic          shift_q, shift_d;
   logic          map_ok_q, map_ok_d;
   logic [2:0]    byte_idx_q, byte_idx_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [HW-1:0] half_cnt_q, half_cnt_d;
   logic          phase_q, phase_d;      // 0: clock high half, 1: clock low half
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          unmapped_q, unmapped_d;
   logic          ps2_clk_q, ps2_clk_d;
   logic          ps2_dat_q, ps2_dat_d;

   logic          handshake;
   logic [9:0]    lut;
   logic [7:0]    cur_byte;
   logic [2:0]    last_byte;
   logic [2:0]    data_sel;
   logic          bit_val;

   function automatic logic [7:0] letter_code(input logic [7:0] c);
      logic [7:0] r;
      case (c)
         8'h61: r = 8'h1C;  8'h62: r = 8'h32;  8'h63: r = 8'h21;  8'h64: r = 8'h23;
         8'h65: r = 8'h24;  8'h66: r = 8'h2B;  8'h67: r = 8'h34;  8'h68: r = 8'h33;
         8'h69: r = 8'h43;  8'h6A: r = 8'h3B;  8'h6B: r = 8'h42;  8'h6C: r = 8'h4B;
         8'h6D: r = 8'h3A;  8'h6E: r = 8'h31;  8'h6F: r = 8'h44;  8'h70: r = 8'h4D;
         8'h71: r = 8'h15;  8'h72: r = 8'h2D;  8'h73: r = 8'h1B;  8'h74: r = 8'h2C;
         8'h75: r = 8'h3C;  8'h76: r = 8'h2A;  8'h77: r = 8'h1D;  8'h78: r = 8'h22;
         8'h79: r = 8'h35;  default: r = 8'h1A;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] digit_code(input logic [7:0] c);
      logic [7:0] r;
      case (c)
         8'h30: r = 8'h45;  8'h31: r = 8'h16;  8'h32: r = 8'h1E;  8'h33: r = 8'h26;
         8'h34: r = 8'h25;  8'h35: r = 8'h2E;  8'h36: r = 8'h36;  8'h37: r = 8'h3D;
         8'h38: r = 8'h3E;  default: r = 8'h46;
      endcase
      return r;
   endfunction

   // Result is {mapped, shift, code}.
   function automatic logic [9:0] lookup(input logic [7:0] c);
      logic [9:0] r;
      r = '0;
      if (c >= 8'h61 && c <= 8'h7A)      r = {2'b10, letter_code(c)};
      else if (c >= 8'h41 && c <= 8'h5A) r = {2'b11, letter_code(c | 8'h20)};
      else if (c >= 8'h30 && c <= 8'h39) r = {2'b10, digit_code(c)};
      else begin
         case (c)
            8'h29: r = {2'b11, 8'h45};  8'h21: r = {2'b11, 8'h16};  8'h40: r = {2'b11, 8'h1E};
            8'h23: r = {2'b11, 8'h26};  8'h24: r = {2'b11, 8'h25};  8'h25: r = {2'b11, 8'h2E};
            8'h5E: r = {2'b11, 8'h36};  8'h26: r = {2'b11, 8'h3D};  8'h2A: r = {2'b11, 8'h3E};
            8'h28: r = {2'b11, 8'h46};
            8'h60: r = {2'b10, 8'h0E};  8'h2D: r = {2'b10, 8'h4E};  8'h3D: r = {2'b10, 8'h55};
            8'h5B: r = {2'b10, 8'h54};  8'h5D: r = {2'b10, 8'h5B};  8'h5C: r = {2'b10, 8'h5D};
            8'h3B: r = {2'b10, 8'h4C};  8'h27: r = {2'b10, 8'h52};  8'h2C: r = {2'b10, 8'h41};
            8'h2E: r = {2'b10, 8'h49};  8'h2F: r = {2'b10, 8'h4A};
            8'h7E: r = {2'b11, 8'h0E};  8'h5F: r = {2'b11, 8'h4E};  8'h2B: r = {2'b11, 8'h55};
            8'h7B: r = {2'b11, 8'h54};  8'h7D: r = {2'b11, 8'h5B};  8'h7C: r = {2'b11, 8'h5D};
            8'h3A: r = {2'b11, 8'h4C};  8'h22: r = {2'b11, 8'h52};  8'h3C: r = {2'b11, 8'h41};
            8'h3E: r = {2'b11, 8'h49};  8'h3F: r = {2'b11, 8'h4A};
            8'h20: r = {2'b10, 8'h29};  8'h0A: r = {2'b10, 8'h5A};  8'h08: r = {2'b10, 8'h66};
            8'h09: r = {2'b10, 8'h0D};  8'h11: r = {2'b10, 8'h75};  8'h12: r = {2'b10, 8'h6B};
            8'h13: r = {2'b10, 8'h72};  8'h14: r = {2'b10, 8'h74};  8'h0D: r = {2'b10, 8'h6C};
            8'h02: r = {2'b10, 8'h7D};  8'h03: r = {2'b10, 8'h7A};  8'h17: r = {2'b10, 8'h69};
            8'h7F: r = {2'b10, 8'h71};  8'h1A: r = {2'b10, 8'h70};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // ready_q is high only while the FSM idles, so valid & ready implies IDLE.
   assign handshake = ascii_valid & ready_q;

   // Byte currently being framed: unshifted {code,F0,code}, shifted {12,code,F0,code,F0,12}.
   always_comb begin
      cur_byte  = code_q;
      last_byte = shift_q ? 3'd5 : 3'd2;
      if (shift_q) begin
         case (byte_idx_q)
            3'd0:    cur_byte = 8'h12;
            3'd2:    cur_byte = 8'hF0;
            3'd4:    cur_byte = 8'hF0;
            3'd5:    cur_byte = 8'h12;
            default: cur_byte = code_q;
         endcase
      end else if (byte_idx_q == 3'd1) begin
         cur_byte = 8'hF0;
      end
      data_sel = 3'(bit_idx_q - 4'd1);
      case (bit_idx_q)
         4'd0:    bit_val = 1'b0;
         4'd9:    bit_val = ~^cur_byte;
         4'd10:   bit_val = 1'b1;
         default: bit_val = cur_byte[data_sel];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      shift_d    = shift_q;
      map_ok_d   = map_ok_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      half_cnt_d = half_cnt_q;
      phase_d    = phase_q;
      gap_cnt_d  = gap_cnt_q;
      unmapped_d = 1'b0;
      lut        = lookup(ascii_in);
      case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d = LOAD;
               {map_ok_d, shift_d, code_d} = lut;
            end
         end
         LOAD: begin
            if (!map_ok_q) begin
               unmapped_d = 1'b1;
               state_d    = IDLE;
            end else begin
               state_d    = FRAME;
               byte_idx_d = '0;
               bit_idx_d  = '0;
               half_cnt_d = '0;
               phase_d    = 1'b0;
            end
         end
         FRAME: begin
            if (half_cnt_q == HALF_LAST) begin
               half_cnt_d = '0;
               phase_d    = ~phase_q;
               if (phase_q) begin
                  if (bit_idx_q == 4'd10) begin
                     bit_idx_d = '0;
                     if (byte_idx_q == last_byte) begin
                        state_d = IDLE;
                     end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                     end
                  end else begin
                     bit_idx_d = bit_idx_q + 4'd1;
                  end
               end
            end else begin
               half_cnt_d = half_cnt_q + HW'(1);
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d    = FRAME;
               byte_idx_d = byte_idx_q + 3'd1;
               half_cnt_d = '0;
               phase_d    = 1'b0;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // All outputs are registered from the current state, so they trail the
      // FSM by one cycle: start bit two edges after acceptance, and ready
      // stays low for LOAD plus one cycle on the unmapped path.
      ready_d   = (state_q == IDLE) && !handshake;
      busy_d    = ~ready_d;
      ps2_clk_d = ~((state_q == FRAME) && phase_q);
      ps2_dat_d = (state_q == FRAME) ? bit_val : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         code_q     <= '0;
         shift_q    <= 1'b0;
         map_ok_q   <= 1'b0;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         half_cnt_q <= '0;
         phase_q    <= 1'b0;
         gap_cnt_q  <= '0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         unmapped_q <= 1'b0;
         ps2_clk_q  <= 1'b1;
         ps2_dat_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         shift_q    <= shift_d;
         map_ok_q   <= map_ok_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         half_cnt_q <= half_cnt_d;
         phase_q    <= phase_d;
         gap_cnt_q  <= gap_cnt_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         unmapped_q <= unmapped_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_dat_q  <= ps2_dat_d;
      end
   end

   assign ascii_ready = ready_q;
   assign busy        = busy_q;
   assign unmapped    = unmapped_q;
   assign ps2_clk_o   = ps2_clk_q;
   assign ps2_dat_o   = ps2_dat_q;

endmodule

// File: tb/tb_ascii_to_ps2_tx.sv
// tb_ascii_to_ps2_tx
//   Scoreboard bench for ascii_to_ps2_tx. Stimulus pushes the expected byte
//   sequence (or an unmapped event) from a table-driven character model; a
//   host-side monitor decodes PS/2 frames from the lines and pops/compares.
module tb_ascii_to_ps2_tx;
   localparam int unsigned HP = 4;
   localparam int unsigned BG = 8;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] ascii_in;
   logic       ascii_valid;
   logic       ascii_ready;
   logic       ps2_clk_o;
   logic       ps2_dat_o;
   logic       busy;
   logic       unmapped;

   ascii_to_ps2_tx #(.HALF_PERIOD(HP), .BYTE_GAP(BG)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .ascii_in    (ascii_in),
      .ascii_valid (ascii_valid),
      .ascii_ready (ascii_ready),
      .ps2_clk_o   (ps2_clk_o),
      .ps2_dat_o   (ps2_dat_o),
      .busy        (busy),
      .unmapped    (unmapped)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
   endtask

   // Character model: mapped flag, shift flag and make code per ASCII value.
   logic [7:0] m_code  [256];
   logic       m_shift [256];
   logic       m_ok    [256];

   task automatic build_model();
      string lo;
      string up;
      logic [7:0] tab [47];
      logic [7:0] sp_ch [14];
      logic [7:0] sp_cd [14];
      lo = "abcdefghijklmnopqrstuvwxyz0123456789`-=[]0;',./";
      up = "ABCDEFGHIJKLMNOPQRSTUVWXYZ)!@#$%^&*(~_+{}|:0<>?";
      lo.putc(41, 8'h5C);
      up.putc(43, 8'h22);
      tab = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
              8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
              8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
              8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
              8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
      sp_ch = '{8'h20, 8'h0A, 8'h08, 8'h09, 8'h11, 8'h12, 8'h13, 8'h14, 8'h0D, 8'h02,
                8'h03, 8'h17, 8'h7F, 8'h1A};
      sp_cd = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h6C, 8'h7D,
                8'h7A, 8'h69, 8'h71, 8'h70};
      for (int i = 0; i < 256; i++) begin
         m_ok[i] = 1'b0; m_shift[i] = 1'b0; m_code[i] = 8'h00;
      end
      for (int i = 0; i < 47; i++) begin
         m_ok[8'(lo[i])] = 1'b1; m_shift[8'(lo[i])] = 1'b0; m_code[8'(lo[i])] = tab[i];
         m_ok[8'(up[i])] = 1'b1; m_shift[8'(up[i])] = 1'b1; m_code[8'(up[i])] = tab[i];
      end
      for (int i = 0; i < 14; i++) begin
         m_ok[sp_ch[i]] = 1'b1; m_shift[sp_ch[i]] = 1'b0; m_code[sp_ch[i]] = sp_cd[i];
      end
   endtask

   // Cycles ready stays low after acceptance: 2 cycles to the start bit,
   // n frames of 22 half periods, n-1 gaps; unmapped characters take 2.
   function automatic int seq_len(input logic [7:0] c);
      int n;
      if (!m_ok[c]) return 2;
      n = m_shift[c] ? 6 : 3;
      return 2 + n * 22 * HP + (n - 1) * BG;
   endfunction

   typedef struct {
      logic [8:0] v;      // 9'h100 marks an unmapped event
      bit         first;
      int         acc;
   } exp_t;
   exp_t exp_q[$];

   task automatic push_expected(input logic [7:0] c, input int acc);
      logic [7:0] seq [$];
      exp_t e;
      if (!m_ok[c]) begin
         e.v = 9'h100; e.first = 1'b1; e.acc = acc;
         exp_q.push_back(e);
         return;
      end
      if (m_shift[c]) seq = '{8'h12, m_code[c], 8'hF0, m_code[c], 8'hF0, 8'h12};
      else            seq = '{m_code[c], 8'hF0, m_code[c]};
      foreach (seq[i]) begin
         e.v = {1'b0, seq[i]}; e.first = (i == 0); e.acc = acc;
         exp_q.push_back(e);
      end
   endtask

   // Host-side monitor: samples on the falling clk edge, away from DUT updates.
   initial begin : monitor
      bit         in_frame = 1'b0;
      logic       prev_clk = 1'b1;
      logic       prev_dat = 1'b1;
      int         start_c = 0;
      int         end_c = 0;
      int         nbits = 0;
      int         off;
      logic [10:0] bits;
      logic [10:0] want;
      bit         t_ok;
      exp_t       e;
      bits = '0;
      t_ok = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            in_frame = 1'b0; prev_clk = 1'b1; prev_dat = 1'b1;
            continue;
         end
         if (unmapped) begin
            chk("unmapped_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("unmapped_event", e.v, 9'h100);
            end
         end
         if (!in_frame) begin
            if (prev_clk && !ps2_clk_o) chk("idle_clk", ps2_clk_o, 1);
            if (!ps2_dat_o) begin
               in_frame = 1'b1; start_c = cyc; nbits = 0; bits = '0;
               t_ok = ps2_clk_o;
            end
         end else begin
            off = cyc - start_c;
            if (ps2_dat_o !== prev_dat && (off % (2 * HP)) != 0) t_ok = 1'b0;
            if (prev_clk && !ps2_clk_o) begin
               if (nbits > 10 || off != HP + 2 * HP * nbits) t_ok = 1'b0;
               if (nbits < 11) bits[nbits] = ps2_dat_o;
               nbits++;
            end
            if (!prev_clk && ps2_clk_o && nbits >= 11) begin
               chk("frame_expected", 64'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  want = {1'b1, ~^e.v[7:0], e.v[7:0], 1'b0};
                  chk("frame_kind", e.v[8], 0);
                  chk("frame_bits", bits, want);
                  chk("frame_len", 64'(cyc - start_c), 22 * HP);
                  chk("bit_timing", t_ok, 1);
                  if (e.first) chk("start_latency", 64'(start_c - e.acc), 2);
                  else         chk("byte_gap", 64'(start_c - end_c), BG);
               end
               end_c = cyc;
               in_frame = 1'b0;
            end
         end
         prev_clk = ps2_clk_o;
         prev_dat = ps2_dat_o;
      end
   end

   int last_acc = 0;

   task automatic send_char(input logic [7:0] c);
      bit done;
      done = 1'b0;
      ascii_in = c;
      ascii_valid = 1'b1;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (ascii_ready) begin
            @(posedge clk); #1;
            done = 1'b1;
         end
      end
      ascii_valid = 1'b0;
      chk("accepted", done, 1);
      if (done) begin
         last_acc = cyc;
         push_expected(c, cyc);
      end
   endtask

   task automatic wait_done(input int exp_len);
      int n;
      bit bad;
      bit done;
      n = 0; bad = 1'b0; done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (busy !== ~ascii_ready) bad = 1'b1;
         if (ascii_ready) done = 1'b1;
         else n++;
      end
      chk("ready_low_cycles", n, exp_len);
      chk("busy_is_not_ready", bad, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_and_wait(input logic [7:0] c);
      send_char(c);
      wait_done(seq_len(c));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin : stim
      logic [7:0] c;
      int a1;
      build_model();
      resetn = 1'b0; ascii_valid = 1'b0; ascii_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {ps2_clk_o, ps2_dat_o, ascii_ready, busy, unmapped}, 5'b11100);
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      send_and_wait(8'h61);          // 'a'
      send_and_wait(8'h41);          // 'A'
      send_and_wait(8'h80);          // unmapped

      // Held valid: '1' then '!' queued while busy.
      send_char(8'h31);
      a1 = last_acc;
      send_char(8'h21);
      chk("held_accept_cycle", 64'(last_acc - a1), seq_len(8'h31) + 1);
      wait_done(seq_len(8'h21));

      // Reset during bit 5 of the second frame of 'a'.
      send_char(8'h61);
      repeat (139) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      chk("midseq_reset_outputs", {ps2_clk_o, ps2_dat_o, ascii_ready, busy, unmapped}, 5'b11100);
      resetn = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      send_and_wait(8'h62);          // 'b'

      send_and_wait(8'h0A);
      send_and_wait(8'h11);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 1) c = 8'($urandom_range(32, 127));
         else                           c = 8'($urandom_range(0, 255));
         send_and_wait(c);
      end

      repeat (10) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ascii_to_ps2_tx.md
Name: ascii_to_ps2_tx

Overview:
Keyboard-side PS/2 emulator and the inverse of the team's scan-code-to-ASCII decoder. It accepts one ASCII character per valid/ready handshake and maps it to a set-2 make code plus a shift flag. It then serialises the full make/break byte sequence as PS/2 device-to-host frames on its clock and data outputs. Used to loop back into the keyboard decoder path, and to drive the text/cursor logic from a UART or ROM source.

Parameters:
HALF_PERIOD, 2500, system clocks per PS/2 clock half-period (50 MHz gives 10 kHz PS/2 clock).
BYTE_GAP, 5000, idle clocks (both lines high) between consecutive bytes of a sequence.

Ports:
clk  input  1  system clock, all logic on rising edge.
resetn  input  1  synchronous active-low reset.
ascii_in  input  8  character to send.
ascii_valid  input  1  ascii_in valid.
ascii_ready  output  1  high only in IDLE; a transfer occurs when valid and ready are both high at a clk edge.
ps2_clk_o  output  1  generated PS/2 clock, idle 1.
ps2_dat_o  output  1  PS/2 data, idle 1.
busy  output  1  high from the cycle after acceptance until return to IDLE.
unmapped  output  1  one-cycle pulse when the accepted character has no mapping.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset values:
  - ps2_clk_o=1, ps2_dat_o=1, ascii_ready=1, busy=0, unmapped=0.
  - FSM=IDLE, all counters 0.
- Reset mid-sequence: on the next edge, outputs return to the reset values and the remaining bytes are discarded (no completion of the partial frame).
- Lookup table, registered at acceptance:
  - Lowercase a-z map to the set-2 codes (a=1C … z=1A), shift=0.
  - Uppercase A-Z map to the same codes, shift=1.
  - Digits 0-9 map to 45,16,1E,26,25,2E,36,3D,3E,46, shift=0.
  - Shifted digit symbols ) ! @ # $ % ^ & * ( map to the same codes, shift=1.
  - Unshifted punctuation: ` - = [ ] \ ; ' , . / map to 0E,4E,55,54,5B,5D,4C,52,41,49,4A.
  - Shifted punctuation: ~ _ + { } | : " < > ? map to the same codes, shift=1.
  - Space 20 maps to 29; 0A to 5A; 08 to 66; 09 to 0D.
  - Cursor/control codes, shift=0: 11 to 75, 12 to 6B, 13 to 72, 14 to 74, 0D to 6C, 02 to 7D, 03 to 7A, 17 to 69, 7F to 71, 1A to 70.
  - Everything else, including 00 and ≥80, is unmapped.
- Byte sequence:
  - shift=0: code, F0, code.
  - shift=1: 12, code, F0, code, F0, 12.
- FSM states:
  - IDLE: ready=1. On handshake go to LOAD.
  - LOAD, one cycle: if unmapped, pulse unmapped and go to IDLE; otherwise load byte 0 and go to FRAME.
  - FRAME: serialise 11 bits.
  - GAP: hold BYTE_GAP cycles, then load the next byte into FRAME; after the last byte go to IDLE.
- Unmapped path: ready is low for exactly 2 cycles, and no line activity occurs.
- Frame format, bit order: start 0, d0..d7 LSB first, odd parity (bit = 1 when d has an even number of ones), stop 1.
- Bit timing:
  - For each bit, ps2_dat_o changes on the first cycle of the bit.
  - ps2_clk_o is high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles.
  - The host samples on the falling edge, so data is stable for HALF_PERIOD before and throughout the low phase.
  - A frame lasts exactly 22*HALF_PERIOD cycles.
  - After the stop bit's low phase, ps2_clk_o returns high and ps2_dat_o stays 1.
- Latency: the start bit (ps2_dat_o=0) appears on the first cycle of FRAME, i.e. 2 cycles after the accepting edge.
- Between bytes, exactly BYTE_GAP cycles elapse with both lines at 1.
- Backpressure: a valid asserted while busy is held off (ready=0) and is not lost; it is accepted on the first IDLE cycle.
- Back-to-back characters: ready rises 1 cycle after the final stop-bit low phase ends. No trailing gap is imposed after the last byte.
- Counter widths: the half-period counter is sized to HALF_PERIOD-1 and the gap counter to BYTE_GAP-1; the bit index is 0..10 and the byte index is 0..5.

Test Plan:
1. HALF_PERIOD=4, BYTE_GAP=8; send 0x61 'a'.
   - Required: three frames, 1C, F0, 1C.
   - Frame 1C data bits 0,0,1,1,1,0,0,0 with parity 0.
   - Frame F0 with parity 1.
   - Each frame is 88 cycles with 8-cycle gaps; ready returns after the sequence ends.
2. Send 0x41 'A'.
   - Required: frames 12 (parity 1), 1C, F0, 1C, F0, 12; busy high throughout.
3. Send 0x80.
   - Required: unmapped pulses for 1 cycle; ps2 lines stay 1; ready is low for exactly 2 cycles.
4. Hold valid with 0x31 then 0x21 back-to-back.
   - Required: 0x21 is accepted only after the 16-based '1' sequence completes.
   - Then frames 12, 16, F0, 16, F0, 12 follow.
5. Assert resetn=0 during bit 5 of the second frame.
   - Required: on the next edge both lines are 1, ready=1 and busy=0; a new 'b' then sends 32, F0, 32 cleanly.
6. Send 0x0A then 0x11.
   - Required: 0x0A produces 5A, F0, 5A; 0x11 produces 75, F0, 75.
   - The host-side keyboard decoder recovers 0A and 11.
